// File: rtl/register_file_1r_1w_march_bist_pkg.sv
// March C- BIST shared definitions.
// Holds the march element, operation and controller state encodings, plus
// constant tables describing each element's op count and address direction.
// No ports. This package is imported by the address generator and by the top.
package scm_bist_pkg;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } march_elem_e;

    typedef enum logic [1:0] {
        W0 = 2'd0,
        W1 = 2'd1,
        R0 = 2'd2,
        R1 = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    localparam int NUM_ELEMENTS = 6;

    // Number of ops issued per address in each element.
    localparam logic [1:0] ELEM_NUM_OPS [NUM_ELEMENTS] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    // 1 = element walks addresses N-1 down to 0.
    localparam logic ELEM_DOWN [NUM_ELEMENTS] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Operation issued by an element at op slot 'second' (0 = first op).
    function automatic op_e elem_op(input march_elem_e elem, input logic second);
        op_e op;
        case (elem)
            M0:      op = W0;
            M1, M3:  op = second ? W1 : R0;
            M2, M4:  op = second ? W0 : R1;
            default: op = R0;
        endcase
        return op;
    endfunction

    function automatic logic op_is_read(input op_e op);
        return (op == R0) || (op == R1);
    endfunction

endpackage

// File: rtl/register_file_1r_1w_march_bist_addr_gen.sv
// Address generator for the march engine.
// A load sets the direction and jumps to that direction's first address;
// each step moves one address in the loaded direction.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   load        load start address (0 when up, N-1 when down)
//   load_down   direction taken on load (1 = down)
//   step        advance one address
//   addr        current address
//   last        current address is the final one for this direction
module scm_bist_addr_gen
    import scm_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic down;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            down <= 1'b0;
        end else if (load) begin
            addr <= load_down ? '1 : '0;
            down <= load_down;
        end else if (step) begin
            addr <= down ? (addr - ADDR_WIDTH'(1)) : (addr + ADDR_WIDTH'(1));
        end
    end

    assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/register_file_1r_1w_march_bist.sv
// March C- BIST engine for the 1R/1W latch register-file test port.
// Runs M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1),
// M4 down(r1,w0), M5 up(r0), one op per cycle, comparing each read word
// against Q_T in the following cycle and capturing the first mismatch.
//
// state | meaning
// IDLE  | waiting for start_i after reset
// RUN   | issuing march ops, CSN_T low
// DRAIN | one idle cycle to compare the final read
// DONE  | results valid, done_o held until next start_i
//
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   start_i          start request, honoured in IDLE or DONE only
//   bist_o           BIST select to the wrapper
//   CSN_T, WEN_T     chip select (active low), write enable (0 = write)
//   A_T, D_T, BE_T   address, write data, byte enables
//   Q_T              read data, valid the cycle after a read
//   busy_o, done_o   run in progress / run complete
//   fail_o           sticky mismatch flag
//   fail_addr_o, fail_exp_o, fail_act_o   first mismatch details
module register_file_1r_1w_march_bist
    import scm_bist_pkg::*;
#(
    parameter int                  ADDR_WIDTH   = 5,
    parameter int                  DATA_WIDTH   = 32,
    parameter int                  NUM_BYTE     = DATA_WIDTH / 8,
    parameter logic [DATA_WIDTH-1:0] BACKGROUND = '0,
    parameter bit                  STOP_ON_FAIL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  bist_o,
    output logic                  CSN_T,
    output logic                  WEN_T,
    output logic [ADDR_WIDTH-1:0] A_T,
    output logic [DATA_WIDTH-1:0] D_T,
    output logic [NUM_BYTE-1:0]   BE_T,
    input  logic [DATA_WIDTH-1:0] Q_T,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_exp_o,
    output logic [DATA_WIDTH-1:0] fail_act_o
);

    bist_state_e state, state_next;
    march_elem_e elem, next_elem;
    logic        op_idx;
    op_e         cur_op;
    logic        op_last, elem_last, seq_end;
    logic        start, mismatch;

    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_last;
    logic                  ag_load, ag_load_down, ag_step;

    logic                  cmp_valid;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic [DATA_WIDTH-1:0] write_data, read_exp;

    always_comb begin
        cur_op     = elem_op(elem, op_idx);
        op_last    = ({1'b0, op_idx} == (ELEM_NUM_OPS[elem] - 2'd1));
        elem_last  = (elem == M5);
        // Saturating at M5 keeps the table index in range.
        next_elem  = elem_last ? M5 : march_elem_e'(elem + 3'd1);
        seq_end    = op_last && addr_last && elem_last;
        start      = start_i && ((state == IDLE) || (state == DONE));
        // Compare is only meaningful while the read pipeline belongs to this run.
        mismatch   = cmp_valid && ((state == RUN) || (state == DRAIN)) && (Q_T != cmp_exp);
        write_data = (cur_op == W1) ? ~BACKGROUND : BACKGROUND;
        read_exp   = (cur_op == R1) ? ~BACKGROUND : BACKGROUND;
    end

    always_comb begin
        ag_load      = start || ((state == RUN) && op_last && addr_last && !elem_last);
        ag_load_down = start ? ELEM_DOWN[M0] : ELEM_DOWN[next_elem];
        ag_step      = (state == RUN) && op_last && !addr_last;
    end

    scm_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .addr      (addr),
        .last      (addr_last)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start_i) state_next = RUN;
            RUN: begin
                if (STOP_ON_FAIL && mismatch) state_next = DONE;
                else if (seq_end)             state_next = DRAIN;
            end
            DRAIN:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bist_o = 1'b0;
        busy_o = 1'b0;
        done_o = 1'b0;
        CSN_T  = 1'b1;
        WEN_T  = 1'b1;
        A_T    = '0;
        D_T    = '0;
        BE_T   = '1;
        case (state)
            RUN: begin
                bist_o = 1'b1;
                busy_o = 1'b1;
                CSN_T  = 1'b0;
                WEN_T  = op_is_read(cur_op);
                A_T    = addr;
                D_T    = op_is_read(cur_op) ? '0 : write_data;
            end
            DRAIN: begin
                bist_o = 1'b1;
                busy_o = 1'b1;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Element / op-slot sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem   <= M0;
            op_idx <= 1'b0;
        end else if (start) begin
            elem   <= M0;
            op_idx <= 1'b0;
        end else if (state == RUN) begin
            if (op_last) begin
                op_idx <= 1'b0;
                if (addr_last && !elem_last) elem <= next_elem;
            end else begin
                op_idx <= 1'b1;
            end
        end
    end

    // Read-compare pipeline: expected word lines up with Q_T one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_valid <= 1'b0;
            cmp_exp   <= '0;
            cmp_addr  <= '0;
        end else begin
            cmp_valid <= (state == RUN) && op_is_read(cur_op);
            cmp_exp   <= read_exp;
            cmp_addr  <= addr;
        end
    end

    // First-failure capture, cleared on each new start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_exp_o  <= '0;
            fail_act_o  <= '0;
        end else if (start) begin
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_exp_o  <= '0;
            fail_act_o  <= '0;
        end else if (mismatch && !fail_o) begin
            fail_o      <= 1'b1;
            fail_addr_o <= cmp_addr;
            fail_exp_o  <= cmp_exp;
            fail_act_o  <= Q_T;
        end
    end

endmodule

// File: tb/tb_register_file_1r_1w_march_bist.sv
// Self-checking bench: behavioural memories with injectable faults feed two
// engines (run-to-end and stop-on-fail); a March C- reference model predicts
// the op sequence and first failure of every run.
module tb_register_file_1r_1w_march_bist;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int N  = 32;
    localparam logic [DW-1:0] BG = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic start_s = 1'b0;

    always #5 clk = ~clk;

    logic          bist, csn, wen, busy, done, fail;
    logic [AW-1:0] a, fail_addr;
    logic [DW-1:0] d, q, fail_exp, fail_act;
    logic [NB-1:0] be;

    logic          bist_s, csn_s, wen_s, busy_s, done_s, fail_s;
    logic [AW-1:0] a_s, fail_addr_s;
    logic [DW-1:0] d_s, q_s, fail_exp_s, fail_act_s;
    logic [NB-1:0] be_s;

    register_file_1r_1w_march_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB),
        .BACKGROUND(BG), .STOP_ON_FAIL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .bist_o(bist),
        .CSN_T(csn), .WEN_T(wen), .A_T(a), .D_T(d), .BE_T(be), .Q_T(q),
        .busy_o(busy), .done_o(done), .fail_o(fail),
        .fail_addr_o(fail_addr), .fail_exp_o(fail_exp), .fail_act_o(fail_act)
    );

    register_file_1r_1w_march_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB),
        .BACKGROUND(BG), .STOP_ON_FAIL(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst), .start_i(start_s), .bist_o(bist_s),
        .CSN_T(csn_s), .WEN_T(wen_s), .A_T(a_s), .D_T(d_s), .BE_T(be_s), .Q_T(q_s),
        .busy_o(busy_s), .done_o(done_s), .fail_o(fail_s),
        .fail_addr_o(fail_addr_s), .fail_exp_o(fail_exp_s), .fail_act_o(fail_act_s)
    );

    // Fault configuration: 0 none, 1 stuck bit, 2 write to 5 also hits 4
    int   fm = 0, fa = 0, fb = 0;
    logic fv = 1'b0;

    logic [DW-1:0] mem   [N];
    logic [DW-1:0] mem_s [N];
    logic [DW-1:0] rdv, rdv_s;

    always @(posedge clk) begin
        if (!csn) begin
            if (wen) begin
                rdv = mem[a];
                if (fm == 1 && int'(a) == fa) rdv[fb] = fv;
                q <= rdv;
            end else begin
                mem[a] <= d;
                if (fm == 2 && a == 5'd5) mem[4] <= d;
            end
        end
    end

    // Stop-on-fail memory: bit 3 of address 7 permanently stuck at 1
    always @(posedge clk) begin
        if (!csn_s) begin
            if (wen_s) begin
                rdv_s = mem_s[a_s];
                if (a_s == 5'd7) rdv_s[3] = 1'b1;
                q_s <= rdv_s;
            end else begin
                mem_s[a_s] <= d_s;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // op codes: 0 w0, 1 w1, 2 r0, 3 r1
    function automatic int march_op(input int e, input int j);
        case (e)
            0:       return 0;
            1, 3:    return (j == 0) ? 2 : 1;
            2, 4:    return (j == 0) ? 3 : 0;
            default: return 2;
        endcase
    endfunction

    logic [37:0] exp_ops [$];

    task automatic ref_march(input int m, input int fad, input int fbit, input logic fval,
                             output logic rf, output int raddr, output logic [DW-1:0] rexp,
                             output logic [DW-1:0] ract, output int rop);
        logic [DW-1:0] arr [N];
        logic [DW-1:0] val, rd, ev;
        int nop, ai, op;
        exp_ops.delete();
        rf = 1'b0; raddr = 0; rexp = '0; ract = '0; rop = 0; nop = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                ai = (e == 3 || e == 4) ? (N - 1 - k) : k;
                for (int j = 0; j < ((e == 0 || e == 5) ? 1 : 2); j++) begin
                    op = march_op(e, j);
                    nop++;
                    if (op < 2) begin
                        val = (op == 1) ? ~BG : BG;
                        arr[ai] = val;
                        if (m == 2 && ai == 5) arr[4] = val;
                        exp_ops.push_back({1'b1, ai[4:0], val});
                    end else begin
                        rd = arr[ai];
                        if (m == 1 && ai == fad) rd[fbit] = fval;
                        ev = (op == 3) ? ~BG : BG;
                        exp_ops.push_back({1'b0, ai[4:0], 32'h0});
                        if (rd != ev && !rf) begin
                            rf = 1'b1; raddr = ai; rexp = ev; ract = rd; rop = nop;
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_march(input string name, input int m, input int fad, input int fbit,
                             input logic fval, input int mid_start);
        logic rf;
        int raddr, rop, cyc, nlow, nrd, nwr, seqerr;
        logic [DW-1:0] rexp, ract;
        logic [37:0] eo;
        bit to;
        fm = m; fa = fad; fb = fbit; fv = fval;
        ref_march(m, fad, fbit, fval, rf, raddr, rexp, ract, rop);
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        cyc = 1; nlow = 0; nrd = 0; nwr = 0; seqerr = 0; to = 1'b0;
        check({name, "_cycle1"}, {busy, bist, fail, done, csn}, 5'b11000);
        while (!done) begin
            if (!csn) begin
                nlow++;
                if (wen) nrd++; else nwr++;
                if (exp_ops.size() == 0) seqerr++;
                else begin
                    eo = exp_ops.pop_front();
                    if ({~wen, a, d} !== eo) seqerr++;
                end
            end
            if (be !== 4'hF) seqerr++;
            start_i = (mid_start > 0 && cyc == mid_start);
            if (cyc >= 2000) begin to = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        check({name, "_timeout"}, to, 1'b0);
        check({name, "_op_seq_errs"}, seqerr, 0);
        check({name, "_csn_low"}, nlow, 10 * N);
        check({name, "_writes"}, nwr, 5 * N);
        check({name, "_reads"}, nrd, 5 * N);
        check({name, "_done_cycle"}, cyc, 10 * N + 2);
        check({name, "_done_ctrl"}, {busy, bist, csn}, 3'b001);
        check({name, "_fail"}, fail, rf);
        check({name, "_fail_addr"}, fail_addr, raddr[4:0]);
        check({name, "_fail_exp"}, fail_exp, rexp);
        check({name, "_fail_act"}, fail_act, ract);
    endtask

    initial begin
        int cyc, last_low, det, raddr, rop;
        logic rf;
        logic [DW-1:0] rexp, ract;
        bit to;

        repeat (3) @(negedge clk);
        check("reset_ctrl", {bist, csn, wen, busy, done, fail}, 6'b011000);
        check("reset_a_d_be", {a, d, be}, {5'd0, 32'd0, 4'hF});
        check("reset_fail_regs", {fail_addr, fail_exp, fail_act}, 69'd0 >> 5);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_access", {csn, done}, 2'b10);

        run_march("clean", 0, 0, 0, 1'b0, 0);
        run_march("stuck7b3", 1, 7, 3, 1'b1, 0);
        run_march("decoder5to4", 2, 0, 0, 1'b0, 150);
        run_march("clean_after_fail", 0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            run_march($sformatf("rand%0d", i), 1, int'($urandom_range(N - 1, 0)),
                      int'($urandom_range(DW - 1, 0)), 1'($urandom_range(1, 0)),
                      int'($urandom_range(315, 2)));
        end

        // Stop-on-fail engine with bit 3 of address 7 stuck at 1
        ref_march(1, 7, 3, 1'b1, rf, raddr, rexp, ract, rop);
        det = rop + 1;
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        cyc = 1; last_low = 0; to = 1'b0;
        while (!done_s) begin
            if (!csn_s) last_low = cyc;
            if (cyc >= 2000) begin to = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
        repeat (5) begin
            @(negedge clk);
            cyc++;
            if (!csn_s) last_low = cyc;
        end
        check("stop_timeout", to, 1'b0);
        check("stop_last_csn_low", last_low, det);
        check("stop_done_cycle", cyc - 5, det + 1);
        check("stop_fail", fail_s, 1'b1);
        check("stop_fail_addr", fail_addr_s, 5'd7);
        check("stop_fail_exp", fail_exp_s, 32'h0);
        check("stop_fail_act", fail_act_s, 32'h8);

        // Reset in the middle of a failing run
        fm = 1; fa = 7; fb = 3; fv = 1'b1;
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        repeat (99) @(negedge clk);
        check("pre_reset_fail", {fail, busy}, 2'b11);
        rst = 1'b1;
        #1;
        check("midrst_ctrl", {bist, csn, wen, busy, done, fail}, 6'b011000);
        check("midrst_a_d_be", {a, d, be}, {5'd0, 32'd0, 4'hF});
        check("midrst_fail_addr", fail_addr, 5'd0);
        check("midrst_fail_exp_act", {fail_exp, fail_act}, 64'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {busy, done, csn}, 3'b001);
        run_march("clean_after_rst", 0, 0, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
